// File: rtl/frogger_input_pkg.sv
// frogger_input_pkg: shared channel state encoding, button ids and counter sizing
package frogger_input_pkg;
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} btn_state_t;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  function automatic int cnt_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce FSM and one-shot move pulse for one button (optional repeat via AUTO_REPEAT_EN)
module button_channel
  import frogger_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic need_reset_i,
  input  logic pressed_i,
  output logic move_o,
  output logic held_o
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_channel: parameter out of range");
  end
  logic [SYNC_STAGES-1:0] sync_q;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic held_q, held_d;
  logic move_q, move_d;
  logic press_pulse;
  logic s;
  assign s = sync_q[SYNC_STAGES-1];
  // Shift the raw level through the synchroniser chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pressed_i};
  end
  // Debounce FSM: a level must be seen DEBOUNCE_CYCLES+1 times in a row to be accepted
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    press_pulse = 1'b0;
    unique case (state_q)
      IDLE: if (s) begin
        state_d = DB_PRESS;
        cnt_d   = ONE;
      end
      DB_PRESS: if (!s) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q < DB_MAX) begin
        cnt_d = cnt_q + ONE;
      end else begin
        state_d     = HELD;
        cnt_d       = '0;
        held_d      = 1'b1;
        press_pulse = ~need_reset_i;
      end
      HELD: if (!s) begin
        state_d = DB_REL;
        cnt_d   = ONE;
      end
      DB_REL: if (s) begin
        state_d = HELD;
        cnt_d   = '0;
      end else if (cnt_q < DB_MAX) begin
        cnt_d = cnt_q + ONE;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RMAX);
  logic [RW-1:0] rep_q, rep_d, rep_lim;
  logic first_q, first_d;
  logic rep_hit, rep_fire;
  // Repeat schedule: first gap REPEAT_DELAY, later gaps REPEAT_PERIOD; keeps time through short release glitches
  always_comb begin
    rep_lim  = first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    rep_hit  = rep_q == rep_lim;
    rep_fire = (state_q == HELD) && rep_hit;
    rep_d    = rep_q;
    first_d  = first_q;
    if (state_q == DB_PRESS && state_d == HELD) begin
      rep_d   = '0;
      first_d = 1'b1;
    end else if (state_q == HELD || state_q == DB_REL) begin
      rep_d   = rep_hit ? '0 : rep_q + RW'(1);
      first_d = rep_hit ? 1'b0 : first_q;
    end else begin
      rep_d   = '0;
      first_d = 1'b1;
    end
  end
  // Repeat counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end
  assign move_d = press_pulse | (rep_fire & ~need_reset_i);
`else
  assign move_d = press_pulse;
`endif
  // FSM, debounce counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      move_q  <= move_d;
    end
  end
  assign move_o = move_q;
  assign held_o = held_q;
endmodule

// File: rtl/multi_button_input.sv
// multi_button_input: N independent debounced push-button channels producing one-shot move pulses (AUTO_REPEAT_EN adds auto-repeat)
module multi_button_input
  import frogger_input_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             needReset,
  input  logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] move,
  output logic [N_BTN-1:0] held
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .need_reset_i(needReset),
      .pressed_i   (pressed[i]),
      .move_o      (move[i]),
      .held_o      (held[i])
    );
  end
endmodule

// File: tb/tb_multi_button_input.sv
// tb_multi_button_input: directed self-checking bench for multi_button_input (AUTO_REPEAT_EN selects the repeat scenario)
module tb_multi_button_input;
  logic clk = 1'b0;
  logic reset, needReset;
  logic [3:0] pressed, move, held;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multi_button_input dut (
    .clk      (clk),
    .reset    (reset),
    .needReset(needReset),
    .pressed  (pressed),
    .move     (move),
    .held     (held)
  );
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [3:0] exp_m;
    reset = 1'b1; needReset = 1'b0; pressed = 4'b0001;
    cyc(3);
    checks++; if (move !== 4'b0) begin fails++; $display("FAIL reset_move got %b want 0000", move); end
    checks++; if (held !== 4'b0) begin fails++; $display("FAIL reset_held got %b want 0000", held); end
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cyc(1);
      exp_m = (n == 7) ? 4'b0001 : 4'b0000;
      checks++; if (move !== exp_m) begin fails++; $display("FAIL first_press_move n=%0d got %b want %b", n, move, exp_m); end
    end
    checks++; if (held !== 4'b0001) begin fails++; $display("FAIL first_press_held got %b want 0001", held); end
    pressed = 4'b0;
    cyc(10);
    checks++; if (held !== 4'b0) begin fails++; $display("FAIL first_release_held got %b want 0000", held); end
  endtask
  task automatic test_glitch;
    logic [3:0] seen;
    seen = 4'b0;
    pressed = 4'b0010;
    cyc(3);
    pressed = 4'b0;
    for (int n = 0; n < 12; n++) begin
      cyc(1);
      seen |= move | held;
    end
    checks++; if (seen !== 4'b0) begin fails++; $display("FAIL glitch_no_pulse got move|held %b want 0000", seen); end
  endtask
  task automatic test_hold;
    int pulses;
    pulses = 0;
    pressed = 4'b0001;
    for (int n = 0; n < 100; n++) begin
      cyc(1);
      if (move[0]) pulses++;
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL hold_one_pulse got %0d want 1", pulses); end
    pressed = 4'b0;
    cyc(6);
    checks++; if (held[0] !== 1'b1) begin fails++; $display("FAIL hold_release_early got %b want 1", held[0]); end
    cyc(1);
    checks++; if (held[0] !== 1'b0) begin fails++; $display("FAIL hold_release_fall got %b want 0", held[0]); end
    cyc(4);
  endtask
  task automatic test_simultaneous;
    logic [3:0] exp_m;
    pressed = 4'b1010;
    for (int n = 1; n <= 8; n++) begin
      cyc(1);
      exp_m = (n == 7) ? 4'b1010 : 4'b0000;
      checks++; if (move !== exp_m) begin fails++; $display("FAIL simultaneous_move n=%0d got %b want %b", n, move, exp_m); end
    end
    checks++; if (held !== 4'b1010) begin fails++; $display("FAIL simultaneous_held got %b want 1010", held); end
    pressed = 4'b0;
    cyc(10);
  endtask
  task automatic test_inhibit;
    int pulses;
    logic [3:0] exp_m;
    needReset = 1'b1;
    pulses = 0;
    pressed = 4'b0100;
    for (int n = 0; n < 20; n++) begin cyc(1); if (move[2]) pulses++; end
    checks++; if (held[2] !== 1'b1) begin fails++; $display("FAIL inhibit_held got %b want 1", held[2]); end
    pressed = 4'b0;
    for (int n = 0; n < 10; n++) begin cyc(1); if (move[2]) pulses++; end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL inhibit_press_release got %0d pulses want 0", pulses); end
    pulses = 0;
    pressed = 4'b0100;
    cyc(15);
    needReset = 1'b0;
    for (int n = 0; n < 20; n++) begin cyc(1); if (move[2]) pulses++; end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL inhibit_consumed got %0d pulses want 0", pulses); end
    pressed = 4'b0;
    cyc(10);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    pulses = 0;
    pressed = 4'b0100;
    for (int n = 1; n <= 15; n++) begin
      cyc(1);
      if (move[2]) pulses++;
      if (n == 7) begin
        checks++; if (move !== 4'b0100) begin fails++; $display("FAIL inhibit_repress_move got %b want 0100", move); end
      end
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL inhibit_repress_count got %0d want 1", pulses); end
    pressed = 4'b0;
    cyc(10);
    pressed = 4'b0001;
    cyc(4);
    reset = 1'b1;
    #1;
    checks++; if (held !== 4'b0 || move !== 4'b0) begin fails++; $display("FAIL midpress_reset got move %b held %b want 0", move, held); end
    cyc(2);
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cyc(1);
      exp_m = (n == 7) ? 4'b0001 : 4'b0000;
      checks++; if (move !== exp_m) begin fails++; $display("FAIL midpress_repress n=%0d got %b want %b", n, move, exp_m); end
    end
    pressed = 4'b0;
    cyc(10);
  endtask
`ifdef AUTO_REPEAT_EN
  task automatic test_repeat;
    int pos[$];
    int want[5] = '{7, 39, 47, 55, 63};
    logic dropped;
    dropped = 1'b0;
    pressed = 4'b1000;
    for (int n = 1; n <= 90; n++) begin
      cyc(1);
      if (move[3]) pos.push_back(n);
      if (n >= 8 && n <= 60 && !held[3]) dropped = 1'b1;
      if (n == 27) pressed = 4'b0;
      if (n == 29) pressed = 4'b1000;
      if (n == 60) pressed = 4'b0;
    end
    checks++; if (pos.size() !== 5) begin fails++; $display("FAIL repeat_count got %0d want 5", pos.size()); end
    for (int i = 0; i < 5 && i < pos.size(); i++) begin
      checks++; if (pos[i] !== want[i]) begin fails++; $display("FAIL repeat_pos[%0d] got %0d want %0d", i, pos[i], want[i]); end
    end
    checks++; if (dropped !== 1'b0) begin fails++; $display("FAIL repeat_glitch_held got drop %b want 0", dropped); end
    cyc(10);
  endtask
`endif
  initial begin
    test_reset();
    test_glitch();
`ifdef AUTO_REPEAT_EN
    test_repeat();
`else
    test_hold();
`endif
    test_simultaneous();
    test_inhibit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
